// File: rtl/scdatamem_bytelane.sv
// Byte-lane data memory for the single-cycle CPU.
// Falling-edge updates, zero-fill sweep after reset, sticky fault record.
module scdatamem_bytelane #(
    parameter int          DEPTH_LOG2     = 10,
    parameter logic [31:0] BASE_ADDR      = 32'h1001_0000,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] datain,
    input  logic        we,
    input  logic        re,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic        fault_clr,
    output logic [31:0] dataout,
    output logic        busy,
    output logic        misalign,
    output logic        out_of_range,
    output logic        fault,
    output logic [31:0] fault_addr,
    output logic        fault_we
);

    localparam int          DEPTH = 1 << DEPTH_LOG2;
    localparam logic [32:0] LIMIT = 33'd4 << DEPTH_LOG2;

    typedef enum logic {INIT, READY} state_t;

    state_t                state;
    logic [DEPTH_LOG2-1:0] cnt;
    logic [31:0]           mem [DEPTH];

    logic [31:0]           off;
    logic [DEPTH_LOG2-1:0] idx;
    logic [1:0]            lane;
    logic                  legal;
    logic                  fev;
    logic [3:0]            wmask;
    logic [31:0]           wdata;
    logic [31:0]           word;
    logic [15:0]           hb;
    logic [7:0]            bb;

    // Offset below BASE_ADDR wraps to a huge value and lands out of range
    assign off          = addr - BASE_ADDR;
    assign idx          = off[DEPTH_LOG2+1:2];
    assign lane         = off[1:0];
    assign out_of_range = {1'b0, off} >= LIMIT;
    assign legal        = (state == READY) && !misalign && !out_of_range;
    assign fev          = (we | re) & (misalign | out_of_range);

    // Alignment check for the requested access size
    always_comb begin
        misalign = 1'b1;
        unique case (size)
            2'b00: misalign = 1'b0;
            2'b01: misalign = addr[0];
            2'b10: misalign = addr[1:0] != 2'b00;
            2'b11: misalign = 1'b1;
        endcase
    end

    // Lane mask and replicated store data
    always_comb begin
        wmask = 4'b0000;
        wdata = 32'h0;
        unique case (size)
            2'b00: begin
                wmask = 4'b0001 << lane;
                wdata = {4{datain[7:0]}};
            end
            2'b01: begin
                wmask = lane[1] ? 4'b1100 : 4'b0011;
                wdata = {2{datain[15:0]}};
            end
            2'b10: begin
                wmask = 4'b1111;
                wdata = datain;
            end
            2'b11: begin
                wmask = 4'b0000;
                wdata = 32'h0;
            end
        endcase
    end

    // Array writes: sweep clear while INIT, masked stores once READY
    always_ff @(negedge clk) begin
        if (state == INIT) begin
            mem[cnt] <= 32'h0;
        end else if (legal && we) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Sweep sequencing and first-fault-wins capture
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= CLEAR_ON_RESET ? INIT : READY;
            busy       <= CLEAR_ON_RESET;
            cnt        <= '0;
            fault      <= 1'b0;
            fault_addr <= 32'h0;
            fault_we   <= 1'b0;
        end else begin
            unique case (state)
                INIT: begin
                    cnt <= cnt + 1'b1;
                    if (&cnt) begin
                        state <= READY;
                        busy  <= 1'b0;
                    end
                end
                READY: begin
                    if (fev && (!fault || fault_clr)) begin
                        fault      <= 1'b1;
                        fault_addr <= addr;
                        fault_we   <= we;
                    end else if (fault_clr) begin
                        fault      <= 1'b0;
                        fault_addr <= 32'h0;
                        fault_we   <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Combinational load path with lane extraction and extension
    always_comb begin
        word    = mem[idx];
        hb      = lane[1] ? word[31:16] : word[15:0];
        bb      = word[{lane, 3'b000} +: 8];
        dataout = 32'h0;
        if (legal) begin
            unique case (size)
                2'b00: dataout = {{24{sign_ext & bb[7]}}, bb};
                2'b01: dataout = {{16{sign_ext & hb[15]}}, hb};
                2'b10: dataout = word;
                2'b11: dataout = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_scdatamem_bytelane.sv
// Self-checking bench for scdatamem_bytelane.
// Load expectations go through a queue scoreboard.
module tb_scdatamem_bytelane;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] datain;
    logic        we;
    logic        re;
    logic [1:0]  size;
    logic        sign_ext;
    logic        fault_clr;
    logic [31:0] dataout;
    logic        busy;
    logic        misalign;
    logic        out_of_range;
    logic        fault;
    logic [31:0] fault_addr;
    logic        fault_we;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q [$];
    string       tag_q [$];

    localparam logic [31:0] B = 32'h1001_0000;

    scdatamem_bytelane #(
        .DEPTH_LOG2    (4),
        .BASE_ADDR     (32'h1001_0000),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .addr        (addr),
        .datain      (datain),
        .we          (we),
        .re          (re),
        .size        (size),
        .sign_ext    (sign_ext),
        .fault_clr   (fault_clr),
        .dataout     (dataout),
        .busy        (busy),
        .misalign    (misalign),
        .out_of_range(out_of_range),
        .fault       (fault),
        .fault_addr  (fault_addr),
        .fault_we    (fault_we)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic sb_pop();
        logic [31:0] e;
        string       t;
        if (exp_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            chk(t, dataout, e);
        end
    endtask

    task automatic load(input string tag, input logic [31:0] a,
                        input logic [1:0] sz, input logic sx,
                        input logic [31:0] exp);
        @(posedge clk);
        #1;
        addr     = a;
        size     = sz;
        sign_ext = sx;
        we       = 1'b0;
        re       = 1'b1;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        #1;
        sb_pop();
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] sz);
        @(posedge clk);
        #1;
        addr   = a;
        datain = d;
        size   = sz;
        we     = 1'b1;
        re     = 1'b0;
        @(negedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic sweep_count(input string tag);
        int n;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            n++;
            if (!busy) break;
        end
        chk(tag, 32'(n), 32'd16);
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        addr      = B;
        datain    = 32'h0;
        we        = 1'b0;
        re        = 1'b0;
        size      = 2'b10;
        sign_ext  = 1'b0;
        fault_clr = 1'b0;
        #22;
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_faddr", fault_addr, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // store to word 2 held across the whole sweep must be ignored
        addr   = B + 32'h8;
        datain = 32'hFFFF_FFFF;
        size   = 2'b10;
        we     = 1'b1;
        re     = 1'b1;
        #1;
        chk("busy_dout", dataout, 32'h0);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            n++;
            if (n == 1) chk("busy_nofault", 32'(fault), 32'd0);
            if (!busy) break;
        end
        chk("sweep_len", 32'(n), 32'd16);
        we = 1'b0;
        re = 1'b0;

        for (int w = 0; w < 16; w++)
            load($sformatf("clr_w%0d", w), B + 32'(4*w), 2'b10, 1'b0, 32'h0);

        store(B + 32'h8, 32'hDEAD_BEEF, 2'b10);
        load("lb_s0", B + 32'h8, 2'b00, 1'b1, 32'hFFFF_FFEF);
        load("lb_s1", B + 32'h9, 2'b00, 1'b1, 32'hFFFF_FFBE);
        load("lb_s2", B + 32'hA, 2'b00, 1'b1, 32'hFFFF_FFAD);
        load("lb_s3", B + 32'hB, 2'b00, 1'b1, 32'hFFFF_FFDE);
        load("lb_z0", B + 32'h8, 2'b00, 1'b0, 32'h0000_00EF);
        load("lb_z1", B + 32'h9, 2'b00, 1'b0, 32'h0000_00BE);
        load("lb_z2", B + 32'hA, 2'b00, 1'b0, 32'h0000_00AD);
        load("lb_z3", B + 32'hB, 2'b00, 1'b0, 32'h0000_00DE);
        load("lh_s2", B + 32'hA, 2'b01, 1'b1, 32'hFFFF_DEAD);
        load("lh_z0", B + 32'h8, 2'b01, 1'b0, 32'h0000_BEEF);
        load("lw_sx", B + 32'h8, 2'b10, 1'b1, 32'hDEAD_BEEF);

        store(B + 32'h9, 32'h0000_0055, 2'b00);
        load("sb_word", B + 32'h8, 2'b10, 1'b0, 32'hDEAD_55EF);
        store(B + 32'hA, 32'h0000_1234, 2'b01);
        load("sh_word", B + 32'h8, 2'b10, 1'b0, 32'h1234_55EF);

        // misaligned half store
        @(posedge clk);
        #1;
        addr   = B + 32'h5;
        datain = 32'hFFFF_FFFF;
        size   = 2'b01;
        we     = 1'b1;
        #1;
        chk("mis_flag", 32'(misalign), 32'd1);
        chk("mis_oor", 32'(out_of_range), 32'd0);
        @(negedge clk);
        #1;
        we = 1'b0;
        chk("f1_fault", 32'(fault), 32'd1);
        chk("f1_addr", fault_addr, B + 32'h5);
        chk("f1_we", 32'(fault_we), 32'd1);
        load("mis_nowr", B + 32'h4, 2'b10, 1'b0, 32'h0);

        // out-of-range load while fault already held
        load("oor_dout", B + 32'h1000, 2'b10, 1'b0, 32'h0);
        chk("oor_flag", 32'(out_of_range), 32'd1);
        @(negedge clk);
        #1;
        chk("f2_addr", fault_addr, B + 32'h5);
        re = 1'b0;

        // clear with simultaneous wrapped-address load
        @(posedge clk);
        #1;
        addr      = 32'h1000_FFFC;
        size      = 2'b10;
        re        = 1'b1;
        fault_clr = 1'b1;
        #1;
        chk("wrap_oor", 32'(out_of_range), 32'd1);
        @(negedge clk);
        #1;
        chk("f3_fault", 32'(fault), 32'd1);
        chk("f3_addr", fault_addr, 32'h1000_FFFC);
        chk("f3_we", 32'(fault_we), 32'd0);
        re = 1'b0;
        @(negedge clk);
        #1;
        fault_clr = 1'b0;
        chk("f4_fault", 32'(fault), 32'd0);
        chk("f4_addr", fault_addr, 32'h0);

        // interrupted sweep restarts at word 0
        store(B + 32'hC, 32'hA5A5_A5A5, 2'b10);
        store(B + 32'h3C, 32'h1111_2222, 2'b10);
        load("w3_set", B + 32'hC, 2'b10, 1'b0, 32'hA5A5_A5A5);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst2_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (7) @(negedge clk);
        @(posedge clk);
        #1;
        chk("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        sweep_count("sweep2_len");
        load("w3_clr", B + 32'hC, 2'b10, 1'b0, 32'h0);
        load("w15_clr", B + 32'h3C, 2'b10, 1'b0, 32'h0);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
